// File: rtl/timer_port_pkg.sv
// Shared definitions for the I/O-port countdown timer: prescaler default,
// status bit positions, control state encoding and the status packing helper.
package timer_port_pkg;

   localparam int PRESC_DEF = 4;

   localparam int ST_RUN  = 0;
   localparam int ST_AR   = 1;
   localparam int ST_IE   = 2;
   localparam int ST_PEND = 3;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

   // Assemble the input-port status byte; the upper nibble always reads as zero.
   function automatic logic [7:0] pack_status(input logic run,
                                              input logic ar,
                                              input logic ie,
                                              input logic pend);
      logic [7:0] st;
      st          = 8'h00;
      st[ST_RUN]  = run;
      st[ST_AR]   = ar;
      st[ST_IE]   = ie;
      st[ST_PEND] = pend;
      return st;
   endfunction

endpackage

// File: rtl/timer_port_presc_div.sv
// Prescaler for the timer: counts enabled cycles and flags the cycle in which
// the count sits at PRESC-1, which is when the timer should decrement.
module presc_div
   import timer_port_pkg::*;
#(
   parameter int PRESC = PRESC_DEF
) (
   input  logic clk,
   input  logic reset,
   input  logic enable,
   input  logic clear,
   output logic tick
);

   localparam int W = $clog2(PRESC);
   localparam logic [W-1:0] LAST_CNT = W'(PRESC - 1);

   logic [W-1:0] cnt_r;

   // Divider counter; a clear restarts a full prescale period.
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_r <= {W{1'b0}};
      end else if (clear) begin
         cnt_r <= {W{1'b0}};
      end else if (enable) begin
         if (cnt_r == LAST_CNT) begin
            cnt_r <= {W{1'b0}};
         end else begin
            cnt_r <= cnt_r + {{(W-1){1'b0}}, 1'b1};
         end
      end else begin
         cnt_r <= cnt_r;
      end
   end

   assign tick = enable && (cnt_r == LAST_CNT);

endmodule

// File: rtl/timer_port.sv
// Programmable countdown timer on the CPU I/O ports: reload/control writes from
// the output-port bus, count/status reads on input ports, level irq on expiry.
module timer_port
   import timer_port_pkg::*;
#(
   parameter int PRESC = PRESC_DEF
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] wdata,
   input  logic       wr_load,
   input  logic       wr_ctrl,
   input  logic       irq_ack,
   output logic [7:0] count_out,
   output logic [7:0] status_out,
   output logic       irq
);

   logic [7:0] reload_r;
   logic [7:0] count_r;
   logic       run_r;
   logic       ar_r;
   logic       ie_r;
   logic       pending_r;
   state_e     state_r;

   logic       tick_s;
   logic       start_s;
   logic       presc_en_s;
   logic       presc_clr_s;

   // A run request only takes effect when a non-zero count is loaded and no
   // reload write shares the cycle (the reload write has priority).
   assign start_s     = wr_ctrl && !wr_load && wdata[0] && (count_r != 8'd0);
   assign presc_en_s  = (state_r == RUN);
   assign presc_clr_s = wr_load || start_s;

   presc_div #(
      .PRESC (PRESC)
   ) u_presc (
      .clk    (clk),
      .reset  (reset),
      .enable (presc_en_s),
      .clear  (presc_clr_s),
      .tick   (tick_s)
   );

   // Register file and control FSM; writes pre-empt any tick in the same cycle.
   always_ff @(posedge clk) begin
      if (reset) begin
         reload_r  <= 8'd0;
         count_r   <= 8'd0;
         run_r     <= 1'b0;
         ar_r      <= 1'b0;
         ie_r      <= 1'b0;
         pending_r <= 1'b0;
         state_r   <= IDLE;
      end else begin
         if (irq_ack) begin
            pending_r <= 1'b0;
         end
         if (wr_load) begin
            reload_r <= wdata;
            count_r  <= wdata;
         end else if (wr_ctrl) begin
            ar_r <= wdata[1];
            ie_r <= wdata[2];
            if (wdata[0]) begin
               if (count_r != 8'd0) begin
                  run_r   <= 1'b1;
                  state_r <= RUN;
               end
            end else begin
               run_r   <= 1'b0;
               state_r <= IDLE;
            end
         end else begin
            case (state_r)
               RUN: begin
                  if (tick_s) begin
                     if (count_r > 8'd1) begin
                        count_r <= count_r - 8'd1;
                     end else if (count_r == 8'd1) begin
                        // Set after the ack clear above so a coincident ack cannot drop it.
                        pending_r <= 1'b1;
                        if (ar_r && (reload_r != 8'd0)) begin
                           count_r <= reload_r;
                        end else begin
                           count_r <= 8'd0;
                           run_r   <= 1'b0;
                           state_r <= DONE;
                        end
                     end else begin
                        // A zero count loaded while running stops without an event.
                        run_r   <= 1'b0;
                        state_r <= DONE;
                     end
                  end
               end
               IDLE: begin
                  state_r <= IDLE;
               end
               DONE: begin
                  state_r <= DONE;
               end
               default: begin
                  run_r   <= 1'b0;
                  state_r <= IDLE;
               end
            endcase
         end
      end
   end

   assign count_out  = count_r;
   assign status_out = pack_status(run_r, ar_r, ie_r, pending_r);
   assign irq        = pending_r && ie_r;

endmodule

// File: tb/tb_timer_port.sv
// Bench for timer_port: a table-driven one-shot run plus hand-written sequences
// for autoreload, coincident events, edge values and reset mid-count.
module tb_timer_port;

   localparam int PRESC = 4;

   logic       clk = 1'b0;
   logic       reset;
   logic [7:0] wdata;
   logic       wr_load;
   logic       wr_ctrl;
   logic       irq_ack;
   logic [7:0] count_out;
   logic [7:0] status_out;
   logic       irq;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic [7:0] c;
      logic [7:0] s;
      logic       i;
   } exp_t;

   typedef struct {
      logic       ld;
      logic       ct;
      logic       ack;
      logic [7:0] d;
      logic [7:0] c;
      logic [7:0] s;
      logic       i;
   } vec_t;

   exp_t sb[$];
   vec_t vecs[17];

   timer_port #(.PRESC(PRESC)) dut (
      .clk        (clk),
      .reset      (reset),
      .wdata      (wdata),
      .wr_load    (wr_load),
      .wr_ctrl    (wr_ctrl),
      .irq_ack    (irq_ack),
      .count_out  (count_out),
      .status_out (status_out),
      .irq        (irq)
   );

   always #5 clk = ~clk;

   function automatic vec_t mkv(input logic ld, input logic ct, input logic ack,
                                input logic [7:0] d, input logic [7:0] c,
                                input logic [7:0] s, input logic i);
      vec_t v;
      v.ld = ld; v.ct = ct; v.ack = ack; v.d = d; v.c = c; v.s = s; v.i = i;
      return v;
   endfunction

   // Drive one cycle of stimulus, queue its expectation, compare after the edge.
   task automatic apply(input logic ld, input logic ct, input logic ack,
                        input logic [7:0] d, input logic [7:0] ec,
                        input logic [7:0] es, input logic ei, input string nm);
      exp_t e;
      wr_load = ld;
      wr_ctrl = ct;
      irq_ack = ack;
      wdata   = d;
      e.c = ec; e.s = es; e.i = ei;
      sb.push_back(e);
      @(posedge clk);
      #1;
      wr_load = 1'b0;
      wr_ctrl = 1'b0;
      irq_ack = 1'b0;
      e = sb.pop_front();
      total++;
      if (count_out !== e.c || status_out !== e.s || irq !== e.i) begin
         bad++;
         $display("FAIL %s: count=%0d status=%h irq=%b, expected count=%0d status=%h irq=%b",
                  nm, count_out, status_out, irq, e.c, e.s, e.i);
      end
   endtask

   task automatic idle(input int n, input logic [7:0] ec, input logic [7:0] es,
                       input logic ei, input string nm);
      for (int k = 0; k < n; k++) begin
         apply(1'b0, 1'b0, 1'b0, 8'h00, ec, es, ei, nm);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      reset   = 1'b1;
      wdata   = 8'h00;
      wr_load = 1'b0;
      wr_ctrl = 1'b0;
      irq_ack = 1'b0;

      // One-shot: load 3, start with ie, expire after 3*PRESC cycles, then ack.
      vecs[0]  = mkv(1'b1, 1'b0, 1'b0, 8'd3,  8'd3, 8'h00, 1'b0);
      vecs[1]  = mkv(1'b0, 1'b1, 1'b0, 8'h05, 8'd3, 8'h05, 1'b0);
      for (int k = 2; k <= 4; k++)  vecs[k] = mkv(1'b0, 1'b0, 1'b0, 8'h00, 8'd3, 8'h05, 1'b0);
      for (int k = 5; k <= 8; k++)  vecs[k] = mkv(1'b0, 1'b0, 1'b0, 8'h00, 8'd2, 8'h05, 1'b0);
      for (int k = 9; k <= 12; k++) vecs[k] = mkv(1'b0, 1'b0, 1'b0, 8'h00, 8'd1, 8'h05, 1'b0);
      vecs[13] = mkv(1'b0, 1'b0, 1'b0, 8'h00, 8'd0, 8'h0C, 1'b1);
      vecs[14] = mkv(1'b0, 1'b0, 1'b1, 8'h00, 8'd0, 8'h04, 1'b0);
      vecs[15] = mkv(1'b0, 1'b1, 1'b0, 8'h01, 8'd0, 8'h00, 1'b0);
      vecs[16] = mkv(1'b0, 1'b0, 1'b0, 8'h00, 8'd0, 8'h00, 1'b0);

      idle(2, 8'd0, 8'h00, 1'b0, "reset_state");
      reset = 1'b0;

      for (int k = 0; k < 17; k++) begin
         apply(vecs[k].ld, vecs[k].ct, vecs[k].ack, vecs[k].d,
               vecs[k].c, vecs[k].s, vecs[k].i, $sformatf("oneshot_vec%0d", k));
      end

      // Autoreload with reload 2: expiry every 8 cycles.
      apply(1'b1, 1'b0, 1'b0, 8'd2,  8'd2, 8'h00, 1'b0, "ar_load");
      apply(1'b0, 1'b1, 1'b0, 8'h07, 8'd2, 8'h07, 1'b0, "ar_start");
      idle(3, 8'd2, 8'h07, 1'b0, "ar_c2");
      idle(4, 8'd1, 8'h07, 1'b0, "ar_c1");
      apply(1'b0, 1'b0, 1'b0, 8'h00, 8'd2, 8'h0F, 1'b1, "ar_exp1");
      apply(1'b0, 1'b0, 1'b1, 8'h00, 8'd2, 8'h07, 1'b0, "ar_ack1");
      idle(2, 8'd2, 8'h07, 1'b0, "ar_c2b");
      idle(4, 8'd1, 8'h07, 1'b0, "ar_c1b");
      apply(1'b0, 1'b0, 1'b0, 8'h00, 8'd2, 8'h0F, 1'b1, "ar_exp2");
      idle(3, 8'd2, 8'h0F, 1'b1, "ar_pend2");
      idle(4, 8'd1, 8'h0F, 1'b1, "ar_pend1");
      // Expiry and irq_ack in the same cycle: pending must survive.
      apply(1'b0, 1'b0, 1'b1, 8'h00, 8'd2, 8'h0F, 1'b1, "exp_ack_same");
      apply(1'b0, 1'b0, 1'b1, 8'h00, 8'd2, 8'h07, 1'b0, "ack_after");
      idle(2, 8'd2, 8'h07, 1'b0, "pre_tick");
      // Load of 9 on a tick cycle: the tick is discarded and a full period restarts.
      apply(1'b1, 1'b0, 1'b0, 8'd9,  8'd9, 8'h07, 1'b0, "load_on_tick");
      idle(3, 8'd9, 8'h07, 1'b0, "after_load9");
      apply(1'b0, 1'b0, 1'b0, 8'h00, 8'd8, 8'h07, 1'b0, "dec_from9");
      apply(1'b0, 1'b1, 1'b0, 8'h00, 8'd8, 8'h00, 1'b0, "stop");
      idle(5, 8'd8, 8'h00, 1'b0, "stopped_hold");

      // wr_load and wr_ctrl together: only the load takes effect.
      apply(1'b1, 1'b1, 1'b0, 8'h07, 8'd7, 8'h00, 1'b0, "load_ctrl_same");
      idle(4, 8'd7, 8'h00, 1'b0, "not_started");

      // ie = 0 at expiry: pending set, irq masked.
      apply(1'b1, 1'b0, 1'b0, 8'd1,  8'd1, 8'h00, 1'b0, "ie0_load");
      apply(1'b0, 1'b1, 1'b0, 8'h01, 8'd1, 8'h01, 1'b0, "ie0_start");
      idle(3, 8'd1, 8'h01, 1'b0, "ie0_run");
      apply(1'b0, 1'b0, 1'b0, 8'h00, 8'd0, 8'h08, 1'b0, "ie0_expire");
      apply(1'b0, 1'b0, 1'b1, 8'h00, 8'd0, 8'h00, 1'b0, "ie0_ack");

      // Load 255: first expiry exactly 255*PRESC cycles after start.
      apply(1'b1, 1'b0, 1'b0, 8'd255, 8'd255, 8'h00, 1'b0, "max_load");
      apply(1'b0, 1'b1, 1'b0, 8'h05,  8'd255, 8'h05, 1'b0, "max_start");
      step(255 * PRESC - 2);
      apply(1'b0, 1'b0, 1'b0, 8'h00, 8'd1, 8'h05, 1'b0, "max_before");
      apply(1'b0, 1'b0, 1'b0, 8'h00, 8'd0, 8'h0C, 1'b1, "max_expire");
      apply(1'b0, 1'b0, 1'b1, 8'h00, 8'd0, 8'h04, 1'b0, "max_ack");

      // Reset mid-count clears everything and no expiry follows.
      apply(1'b1, 1'b0, 1'b0, 8'd5,  8'd5, 8'h04, 1'b0, "rst_load");
      apply(1'b0, 1'b1, 1'b0, 8'h05, 8'd5, 8'h05, 1'b0, "rst_start");
      step(7);
      reset = 1'b1;
      apply(1'b0, 1'b0, 1'b0, 8'h00, 8'd0, 8'h00, 1'b0, "rst_mid");
      reset = 1'b0;
      idle(30, 8'd0, 8'h00, 1'b0, "rst_quiet");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
